// File: rtl/fp_normalize_round_pack_if.sv
// Handshake and operand/result bundle for the FP add/sub normalize-round-pack back end.
interface fp_normalize_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign1;
  logic        sign2;
  logic [7:0]  exp_res;
  logic [47:0] mantissa1_aligned;
  logic [47:0] mantissa2_aligned;
  logic        nan_in;
  logic        inf1;
  logic        inf2;
  logic [2:0]  frm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  modport master (
    output in_valid, sign1, sign2, exp_res, mantissa1_aligned, mantissa2_aligned,
           nan_in, inf1, inf2, frm, out_ready,
    input  in_ready, out_valid, result, fflags
  );

  modport slave (
    input  in_valid, sign1, sign2, exp_res, mantissa1_aligned, mantissa2_aligned,
           nan_in, inf1, inf2, frm, out_ready,
    output in_ready, out_valid, result, fflags
  );
endinterface

// File: rtl/fp_normalize_round_pack.sv
// Add/sub magnitude, normalize, round (RISC-V frm) and pack binary32 with fflags; 4-state FSM.
// Define FP_PACK_BACK2BACK_EN to accept a new bundle in DONE on the same edge as the output handshake.
module fp_normalize_round_pack #(
  parameter logic [31:0] RESET_RESULT = 32'h0000_0000,
  parameter logic [31:0] CANON_NAN    = 32'h7FC0_0000
) (
  input logic                      clk,
  input logic                      rst,
  fp_normalize_round_pack_if.slave bus
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state;
  logic               sign1_q, sign2_q, nan_q, inf1_q, inf2_q;
  logic [7:0]         exp_q;
  logic [47:0]        m1_q, m2_q;
  logic [2:0]         rm_q;
  logic [46:0]        sig_q;
  logic signed [9:0]  e_q;
  logic               sgn_q, zero_q;
  logic               out_valid_q;
  logic [31:0]        result_q;
  logic [4:0]         fflags_q;
  logic               in_ready_c, accept;

`ifdef FP_PACK_BACK2BACK_EN
  assign in_ready_c = (state == IDLE) || (state == DONE && bus.out_ready);
`else
  assign in_ready_c = (state == IDLE);
`endif
  assign accept        = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.fflags    = fflags_q;

  // Magnitude and normalization, evaluated in NORM.
  logic [47:0]       mag;
  logic [46:0]       sig_n;
  logic              sgn_n;
  logic signed [9:0] e_base, e_n;
  logic [5:0]        lz, sh;
  always_comb begin
    sgn_n = sign1_q;
    if (sign1_q == sign2_q)  mag = m1_q + m2_q;
    else if (m1_q >= m2_q)   mag = m1_q - m2_q;
    else begin
      mag   = m2_q - m1_q;
      sgn_n = sign2_q;
    end
    e_base = (exp_q == 8'd0) ? 10'sd1 : $signed({2'b00, exp_q});
    lz = 6'd47;
    for (int unsigned i = 0; i < 47; i++)
      if (mag[i]) lz = 6'(46 - i);
    sh = lz;
    if ($signed({4'b0000, lz}) > e_base - 10'sd1) sh = 6'(e_base - 10'sd1);
    if (mag[47]) begin
      // Right shift by one; the dropped bit is folded into the sticky field.
      sig_n = {mag[47:2], mag[1] | mag[0]};
      e_n   = e_base + 10'sd1;
    end else begin
      sig_n = mag[46:0] << sh;
      e_n   = e_base - $signed({4'b0000, sh});
    end
  end

  // Rounding, overflow and special-case selection, evaluated in ROUND.
  logic [23:0]       kept;
  logic              guard, sticky, inc, ovf, inexact, to_inf;
  logic [24:0]       rnd;
  logic signed [9:0] e_f;
  logic [22:0]       frac_f;
  logic [7:0]        exp_f;
  logic [31:0]       res_n;
  logic [4:0]        flg_n;
  always_comb begin
    kept   = sig_q[46:23];
    guard  = sig_q[22];
    sticky = |sig_q[21:0];
    case (rm_q)
      3'b001:  begin inc = 1'b0;                       to_inf = 1'b0;   end
      3'b010:  begin inc = sgn_q & (guard | sticky);   to_inf = sgn_q;  end
      3'b011:  begin inc = ~sgn_q & (guard | sticky);  to_inf = ~sgn_q; end
      3'b100:  begin inc = guard;                      to_inf = 1'b1;   end
      default: begin inc = guard & (sticky | kept[0]); to_inf = 1'b1;   end
    endcase
    rnd = {1'b0, kept} + {24'd0, inc};
    // A subnormal that rounds into bit 46 picks up exponent 1 through rnd[23].
    if (rnd[24]) begin
      e_f    = e_q + 10'sd1;
      frac_f = '0;
    end else begin
      e_f    = rnd[23] ? e_q : 10'sd0;
      frac_f = rnd[22:0];
    end
    exp_f   = e_f[7:0];
    ovf     = (e_f >= 10'sd255);
    inexact = guard | sticky | ovf;
    if (nan_q) begin
      res_n = CANON_NAN;
      flg_n = '0;
    end else if (inf1_q && inf2_q && (sign1_q != sign2_q)) begin
      res_n = CANON_NAN;
      flg_n = 5'b10000;
    end else if (inf1_q || inf2_q) begin
      res_n = {inf1_q ? sign1_q : sign2_q, 8'hFF, 23'd0};
      flg_n = '0;
    end else if (zero_q) begin
      res_n = {(sign1_q == sign2_q) ? sign1_q : (rm_q == 3'b010), 31'd0};
      flg_n = '0;
    end else if (ovf) begin
      res_n = to_inf ? {sgn_q, 8'hFF, 23'd0} : {sgn_q, 31'h7F7F_FFFF};
      flg_n = 5'b00101;
    end else begin
      res_n = {sgn_q, exp_f, frac_f};
      flg_n = {3'b000, (exp_f == 8'd0) & inexact, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      sign1_q <= bus.sign1;
      sign2_q <= bus.sign2;
      exp_q   <= bus.exp_res;
      m1_q    <= bus.mantissa1_aligned;
      m2_q    <= bus.mantissa2_aligned;
      nan_q   <= bus.nan_in;
      inf1_q  <= bus.inf1;
      inf2_q  <= bus.inf2;
      rm_q    <= bus.frm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= RESET_RESULT;
      fflags_q    <= '0;
    end else begin
      case (state)
        IDLE:  if (accept) state <= NORM;
        NORM: begin
          sig_q  <= sig_n;
          e_q    <= e_n;
          sgn_q  <= sgn_n;
          zero_q <= (mag == 48'd0);
          state  <= ROUND;
        end
        ROUND: begin
          result_q    <= res_n;
          fflags_q    <= flg_n;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= accept ? NORM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_normalize_round_pack.sv
// Directed-vector bench for fp_normalize_round_pack (default build, back-to-back feature off).
module tb_fp_normalize_round_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp_normalize_round_pack_if bus();

  fp_normalize_round_pack #(
    .RESET_RESULT(32'h0000_0000),
    .CANON_NAN   (32'h7FC0_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic drive(input logic s1, input logic s2, input logic [7:0] e,
                       input logic [47:0] m1, input logic [47:0] m2,
                       input logic nan, input logic i1, input logic i2, input logic [2:0] rm);
    bus.sign1 = s1; bus.sign2 = s2; bus.exp_res = e;
    bus.mantissa1_aligned = m1; bus.mantissa2_aligned = m2;
    bus.nan_in = nan; bus.inf1 = i1; bus.inf2 = i2; bus.frm = rm;
  endtask

  // Accepts one bundle and waits for out_valid; out_ready is left to the caller.
  task automatic launch(input string tag, output int edges);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    bus.in_valid = 1'b1;
    @(posedge clk); #1;            // accepting edge counts as edge 1
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 12) begin @(posedge clk); #1; edges++; end
    check_val({tag, "_lat"}, 32'(edges), 32'd3);
  endtask

  task automatic run_op(input string tag, input logic s1, input logic s2, input logic [7:0] e,
                        input logic [47:0] m1, input logic [47:0] m2,
                        input logic nan, input logic i1, input logic i2, input logic [2:0] rm,
                        input logic [31:0] want_res, input logic [4:0] want_fl);
    int edges;
    drive(s1, s2, e, m1, m2, nan, i1, i2, rm);
    bus.out_ready = 1'b1;
    launch(tag, edges);
    check_val({tag, "_res"}, bus.result, want_res);
    check_val({tag, "_flags"}, 32'(bus.fflags), 32'(want_fl));
    @(posedge clk); #1;
    check_val({tag, "_ovdrop"}, 32'(bus.out_valid), 32'd0);
  endtask

  localparam logic [47:0] ONE   = 48'h4000_0000_0000;
  localparam logic [47:0] HALF  = 48'h2000_0000_0000;
  localparam logic [47:0] MAXM  = 48'h7FFF_FF80_0000;
  localparam logic [47:0] TIE   = 48'h0000_0040_0000;
  localparam logic [47:0] ULPX  = 48'h0000_0000_0001;

  initial begin
    int edges;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'd0, '0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_result", bus.result, 32'h0000_0000);
    check_val("rst_fflags", 32'(bus.fflags), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    run_op("one_plus_one", 0, 0, 8'd127, ONE, ONE, 0, 0, 0, 3'b000, 32'h4000_0000, 5'h00);
    run_op("cancel_rne",   0, 1, 8'd127, ONE, ONE, 0, 0, 0, 3'b000, 32'h0000_0000, 5'h00);
    run_op("cancel_rdn",   0, 1, 8'd127, ONE, ONE, 0, 0, 0, 3'b010, 32'h8000_0000, 5'h00);
    run_op("ovf_rne",      0, 0, 8'd254, MAXM, MAXM, 0, 0, 0, 3'b000, 32'h7F80_0000, 5'h05);
    run_op("ovf_rtz",      0, 0, 8'd254, MAXM, MAXM, 0, 0, 0, 3'b001, 32'h7F7F_FFFF, 5'h05);
    run_op("tie_rne",      0, 0, 8'd127, ONE, TIE, 0, 0, 0, 3'b000, 32'h3F80_0000, 5'h01);
    run_op("tie_rup",      0, 0, 8'd127, ONE, TIE, 0, 0, 0, 3'b011, 32'h3F80_0001, 5'h01);
    run_op("tie_mode7",    0, 0, 8'd127, ONE, TIE, 0, 0, 0, 3'b111, 32'h3F80_0000, 5'h01);
    // 0.5 - 1.0: larger operand is op2, left normalize by one.
    run_op("sub_neg_half", 0, 1, 8'd127, HALF, ONE, 0, 0, 0, 3'b000, 32'hBF00_0000, 5'h00);
    // Just below 2^-126: RNE rounds up into the smallest normal, RTZ stays subnormal.
    run_op("sub_rne_up",   0, 1, 8'd1, ONE, ULPX, 0, 0, 0, 3'b000, 32'h0080_0000, 5'h01);
    run_op("sub_rtz_uf",   0, 1, 8'd1, ONE, ULPX, 0, 0, 0, 3'b001, 32'h007F_FFFF, 5'h03);
    run_op("inf_minus_inf",0, 1, 8'd255, ONE, ONE, 0, 1, 1, 3'b000, 32'h7FC0_0000, 5'h10);
    run_op("nan_in",       0, 0, 8'd255, ONE, ONE, 1, 0, 0, 3'b000, 32'h7FC0_0000, 5'h00);
    run_op("inf2_neg",     0, 1, 8'd255, ONE, ONE, 0, 0, 1, 3'b000, 32'hFF80_0000, 5'h00);

    // Backpressure: result held while out_ready is low, stray bundles ignored.
    drive(0, 0, 8'd127, ONE, ONE, 0, 0, 0, 3'b000);
    bus.out_ready = 1'b0;
    launch("bp", edges);
    drive(0, 0, 8'd0, '0, '0, 1, 0, 0, 3'b000);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_result", bus.result, 32'h4000_0000);
      check_val("bp_fflags", 32'(bus.fflags), 32'd0);
      check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_ov", 32'(bus.out_valid), 32'd0);
    check_val("bp_release_ir", 32'(bus.in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check_val("bp_no_stray", 32'(bus.out_valid), 32'd0);

    // Reset while the FSM is in ROUND discards the operation.
    drive(0, 0, 8'd127, ONE, ONE, 0, 0, 0, 3'b000);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_result", bus.result, 32'h0000_0000);
    check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("midrst_discard", 32'(bus.out_valid), 32'd0);

    run_op("after_rst", 0, 0, 8'd127, ONE, ONE, 0, 0, 0, 3'b000, 32'h4000_0000, 5'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round_pack.md
Name: fp_normalize_round_pack

Overview:
- Back end of the FP add/sub datapath. It sits after the extract/align stage.
- It takes the two aligned 48-bit significands, the effective signs, the common exponent and the special-case flags.
- It adds or subtracts magnitudes, normalizes, rounds per RISC-V frm and packs an IEEE-754 binary32 result with fflags.
- It is multi-cycle, with valid/ready on both sides.

Parameters:
- RESET_RESULT, 32'h0000_0000, value driven on result during and after reset.
- CANON_NAN, 32'h7FC0_0000, canonical quiet NaN emitted for every NaN result.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle
- sign1  input  1  effective sign of operand 1
- sign2  input  1  effective sign of operand 2 (already XORed with add_sub)
- exp_res  input  8  common biased exponent after alignment
- mantissa1_aligned  input  48  operand 1 significand: bit47=0 headroom, bit46=hidden, [45:23] fraction, [22:0] extension
- mantissa2_aligned  input  48  operand 2 significand, same format
- nan_in  input  1  either operand is NaN
- inf1  input  1  operand 1 is infinity
- inf2  input  1  operand 2 is infinity
- frm  input  3  rounding mode
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  packed binary32
- fflags  output  5  {NV,DZ,OF,UF,NX}; DZ is always 0

Behaviour:
- Reset, applied synchronously on any cycle including mid-operation:
  - state=IDLE, out_valid=0, result=RESET_RESULT, fflags=0, in_ready=1 on the following cycle.
  - Any in-flight operation is discarded.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture all inputs and go to NORM.
  - NORM: compute the magnitude and shift; go to ROUND.
  - ROUND: round, pack and register result/fflags; go to DONE.
  - DONE: out_valid=1, with result/fflags held stable. On out_ready, go to IDLE.
- Latency: out_valid rises 3 clk edges after the accepting edge. Minimum throughput is 1 result per 4 cycles.
- Inputs are ignored outside IDLE. in_ready=0 in NORM/ROUND/DONE.
- Magnitude:
  - sign1==sign2: S=m1+m2, sign=sign1.
  - Otherwise: larger minus smaller; sign is that of the larger. m1>=m2 picks sign1.
- Effective exponent: E = max(exp_res, 1), so that exp_res=0 denotes subnormal scale.
- Normalize, with width 10-bit signed exponent arithmetic:
  - If S[47]=1: shift right 1, the dropped bit ORs into sticky, E+1.
  - Else: shift left by min(lzc(S[46:0]), E-1), and E is reduced by the shift.
  - If S[46]=0 after shifting, the result is subnormal and the packed exponent is 0.
- Round:
  - Kept bits [46:23], guard bit [22], sticky = OR[21:0].
  - Modes: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100. Values 101–111 are treated as RNE.
  - A rounding carry out of bit 46 gives E+1 and significand 1.0. A subnormal rounding up into bit46 becomes exponent 1.
- Overflow (final E>=255):
  - Result is ±inf for RNE/RMM, for RUP when positive, and for RDN when negative.
  - Otherwise the result is ±0x7F7FFFFF.
  - fflags OF|NX.
- Flags:
  - NX = guard|sticky, or overflow.
  - UF = result is subnormal or zero from a nonzero S, AND NX.
- Exact zero (S=0):
  - Unequal signs: +0, except -0 under RDN.
  - Equal signs: that sign.
  - No flags.
- Specials, with priority over the arithmetic:
  - nan_in: CANON_NAN, no flags.
  - inf1&inf2 with sign1!=sign2: CANON_NAN with NV.
  - Any other infinity: inf of the infinite operand's effective sign.

Optional Feature:
- FP_PACK_BACK2BACK_EN defined: in DONE, in_ready = out_ready.
  - A simultaneous out handshake and in_valid captures the new bundle and goes straight to NORM.
  - Throughput becomes 1 per 3 cycles.
- Undefined: DONE always returns to IDLE first; the behaviour is as described above.

Test Plan:
- 1.0+1.0: exp_res=127, m1=m2=48'h4000_0000_0000, sign1=sign2=0, RNE → result=0x40000000, fflags=0, out_valid exactly 3 edges after accept.
- Cancellation: equal m=48'h4000_0000_0000, exp_res=127, sign1=0, sign2=1 → RNE 0x00000000; RDN 0x80000000; fflags=0.
- Overflow: exp_res=254, m1=m2=48'h7FFF_FF80_0000, signs 0 → RNE 0x7F800000 with fflags=0x05; RTZ 0x7F7FFFFF with fflags=0x05.
- Tie rounding: exp_res=127, m1=48'h4000_0000_0000, m2=48'h0000_0040_0000 → RNE 0x3F800000 with fflags=0x01; RUP 0x3F800001 with fflags=0x01.
- Specials: inf1=inf2=1, sign1=0, sign2=1 → 0x7FC00000, fflags=0x10; nan_in=1 → 0x7FC00000, fflags=0.
- Backpressure/reset:
  - out_ready=0 for 5 cycles: result/fflags stable, in_ready=0, extra in_valid ignored.
  - Assert rst while in ROUND: next cycle out_valid=0, result=0, in_ready=1.
